// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg -- shared definitions for the button event classifier.
//
// Contents:
//   NUM_BTN          number of independent button channels
//   LONG_TICKS_DEF   default ticks for a long press (1 s at a 1 ms tick)
//   DBL_TICKS_DEF    default double-click window in ticks
//   ST_*             3-bit state encodings for the per-channel FSM
//   btn_state_e      enum built on those encodings
//   cnt_width()      tick counter width that holds max(a, b) without wrapping
// -----------------------------------------------------------------------------
package btn_pkg;

  localparam int NUM_BTN        = 2;
  localparam int LONG_TICKS_DEF = 1000;
  localparam int DBL_TICKS_DEF  = 300;

  // Fixed encodings so the state is recognisable on a debug bus or in a dump.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_WAIT2  = 3'd2;
  localparam logic [2:0] ST_PRESS2 = 3'd3;
  localparam logic [2:0] ST_HELD   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_PRESS1 = ST_PRESS1,
    S_WAIT2  = ST_WAIT2,
    S_PRESS2 = ST_PRESS2,
    S_HELD   = ST_HELD
  } btn_state_e;

  // Width needed to represent the larger of two tick thresholds.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_event_ch.sv
// -----------------------------------------------------------------------------
// btn_event_ch -- one button channel: edge detect, tick counter, classifier
// FSM and registered event pulses.
//
// Optional feature: BTN_EVENT_DBLCLK_EN. When defined, a release from PRESS1
// opens a double-click window (WAIT2 / PRESS2). When undefined those states
// are not built, a release from PRESS1 emits shortPress at once, and dblClick
// is tied to 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   tick       one-clk timebase strobe
//   btnDb      debounced button level, 1 = pressed
//   shortPress one-clk pulse on a completed short press
//   longPress  one-clk pulse when the hold reaches LONG_TICKS
//   dblClick   one-clk pulse on a completed double click
//   held       level, 1 while the FSM is in HELD
// -----------------------------------------------------------------------------
module btn_event_ch
  import btn_pkg::*;
#(
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int DBL_TICKS  = DBL_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btnDb,
  output logic shortPress,
  output logic longPress,
  output logic dblClick,
  output logic held
);

  localparam int CW = cnt_width(LONG_TICKS, DBL_TICKS);

  btn_state_e    state;
  btn_state_e    state_nxt;
  logic [CW-1:0] cnt;
  logic          btnPrev;
  logic          press_edge;
  logic          rel_edge;
  logic          long_hit;
  logic          short_nxt;
  logic          long_nxt;

  assign press_edge = btnDb & ~btnPrev;
  assign rel_edge   = ~btnDb & btnPrev;

  // Threshold compares qualify on tick: the counter value seen here is the
  // number of ticks already counted, so the Nth tick is the one with cnt=N-1.
  assign long_hit = tick && (cnt == CW'(LONG_TICKS - 1));

`ifdef BTN_EVENT_DBLCLK_EN
  logic dbl_hit;
  logic dbl_nxt;
  assign dbl_hit = tick && (cnt == CW'(DBL_TICKS - 1));
`endif

  // ---------------------------------------------------------------------------
  // Next-state and pulse decode. Edges are tested before tick thresholds so a
  // release or press in the same cycle as a threshold tick always wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    state_nxt = state;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
`ifdef BTN_EVENT_DBLCLK_EN
    dbl_nxt   = 1'b0;
`endif

    unique case (state)
      S_IDLE: begin
        if (press_edge) state_nxt = S_PRESS1;
      end

      S_PRESS1: begin
        if (rel_edge) begin
`ifdef BTN_EVENT_DBLCLK_EN
          state_nxt = S_WAIT2;
`else
          short_nxt = 1'b1;
          state_nxt = S_IDLE;
`endif
        end else if (long_hit) begin
          long_nxt  = 1'b1;
          state_nxt = S_HELD;
        end
      end

`ifdef BTN_EVENT_DBLCLK_EN
      S_WAIT2: begin
        if (press_edge) begin
          state_nxt = S_PRESS2;
        end else if (dbl_hit) begin
          short_nxt = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      // Second press of a double click: its length does not matter.
      S_PRESS2: begin
        if (rel_edge) begin
          dbl_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
`endif

      S_HELD: begin
        if (rel_edge) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, edge-detect history, tick counter and pulse registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state      <= S_IDLE;
      btnPrev    <= 1'b0;
      cnt        <= '0;
      shortPress <= 1'b0;
      longPress  <= 1'b0;
    end else begin
      state      <= state_nxt;
      btnPrev    <= btnDb;
      shortPress <= short_nxt;
      longPress  <= long_nxt;
      // Cleared on each state change; otherwise counts ticks and saturates.
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (tick && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef BTN_EVENT_DBLCLK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dblClick <= 1'b0;
    else      dblClick <= dbl_nxt;
  end
`else
  assign dblClick = 1'b0;
`endif

  // Decoded straight from the state register, so it is glitch-free and
  // drops with reset without needing a register of its own.
  assign held = (state == S_HELD);

endmodule

// File: rtl/btn_event.sv
// -----------------------------------------------------------------------------
// btn_event -- classifies each debounced button into short press, long press
// and (optionally) double click events. Channels are fully independent.
//
// Optional feature: BTN_EVENT_DBLCLK_EN enables double-click detection; with
// it undefined, dblClick is constant 0 and short presses are reported on
// release.
//
// Parameters:
//   LONG_TICKS  ticks a press must last to be a long press
//   DBL_TICKS   max ticks from first release to second press for a double click
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   tick       one-clk timebase strobe (shared with the debouncer)
//   btnDb      debounced button levels, 1 = pressed
//   shortPress per-button one-clk pulse, completed short press
//   longPress  per-button one-clk pulse, hold reached LONG_TICKS
//   dblClick   per-button one-clk pulse, completed double click
//   held       per-button level, 1 while the long press is being held
// -----------------------------------------------------------------------------
module btn_event
  import btn_pkg::*;
#(
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int DBL_TICKS  = DBL_TICKS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [NUM_BTN-1:0] btnDb,
  output logic [NUM_BTN-1:0] shortPress,
  output logic [NUM_BTN-1:0] longPress,
  output logic [NUM_BTN-1:0] dblClick,
  output logic [NUM_BTN-1:0] held
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_event_ch #(
      .LONG_TICKS (LONG_TICKS),
      .DBL_TICKS  (DBL_TICKS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .btnDb      (btnDb[i]),
      .shortPress (shortPress[i]),
      .longPress  (longPress[i]),
      .dblClick   (dblClick[i]),
      .held       (held[i])
    );
  end

endmodule

// File: doc/btn_event.md
BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 Parameter LONG_TICKS, default 1000: ticks a press must last to count as a long press (1 s at 1 ms tick).
REQ-002 Parameter DBL_TICKS, default 300: maximum ticks from first release to second press for a double click.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low: asserted at 0, released at 1.
REQ-005 tick  input  1  one-clk-wide timebase strobe (1 ms), shared with the debounce stage.
REQ-006 btnDb  input  2  debounced button levels, synchronous to clk, 1 = pressed.
REQ-007 shortPress  output  2  per-button one-clk pulse on a completed short press.
REQ-008 longPress  output  2  per-button one-clk pulse when the hold reaches LONG_TICKS.
REQ-009 dblClick  output  2  per-button one-clk pulse on a completed double click; constant 0 when REQ-025 is off.
REQ-010 held  output  2  per-button level, 1 while in state HELD.

Function
REQ-011 Each button is classified independently by an identical FSM; no interaction between channels.
REQ-012 Edge detect: btnPrev register per bit; press = btnDb & ~btnPrev; release = ~btnDb & btnPrev.
REQ-013 FSM states: IDLE, PRESS1, WAIT2, PRESS2, HELD.
REQ-014 Each channel has one tick counter, cleared on every state change and incremented only on tick; it saturates and never wraps.
REQ-015 The counter is wide enough for max(LONG_TICKS, DBL_TICKS).
REQ-016 IDLE: on press -> PRESS1.
REQ-017 PRESS1, release: -> WAIT2 when double click is enabled; otherwise pulse shortPress and -> IDLE.
REQ-018 PRESS1, no release: on the tick where the counter equals LONG_TICKS-1, pulse longPress and -> HELD.
REQ-019 WAIT2: on press -> PRESS2.
REQ-020 WAIT2, no press: on the tick where the counter equals DBL_TICKS-1, pulse shortPress and -> IDLE.
REQ-021 PRESS2: on release, pulse dblClick and -> IDLE; hold duration is ignored and no longPress is issued.
REQ-022 HELD: held=1; on release -> IDLE with no pulse.
REQ-023 Simultaneous events: a release or press edge takes priority over a tick threshold in the same cycle.
REQ-024 Latency: every pulse is registered and asserts in the cycle after the clk edge on which the triggering edge or tick is sampled; each pulse lasts exactly 1 clk; at most one pulse type per channel per cycle.

Configuration
REQ-025 Macro BTN_EVENT_DBLCLK_EN defined: full FSM per REQ-013..REQ-022.
REQ-026 Macro BTN_EVENT_DBLCLK_EN undefined: WAIT2 and PRESS2 are not built, PRESS1 release emits shortPress immediately, and dblClick is tied 0.

Reset
REQ-027 While rst=0, regardless of clk, all FSMs go to IDLE and counters, btnPrev, shortPress, longPress, dblClick and held go to 0.
REQ-028 Reset mid-operation abandons any press in progress with no pulse.
REQ-029 A button still held when rst releases is seen as a press on the first clk (btnPrev=0).

Structure
REQ-030 Shared package btn_pkg holds the FSM state encoding (3-bit localparams), NUM_BTN=2, and the default LONG_TICKS and DBL_TICKS.
REQ-031 Sub-module btn_event_ch implements one channel (edge detect, counter, FSM, pulse registers).
REQ-032 btn_event instantiates btn_event_ch NUM_BTN times in a generate loop.

Verification (LONG_TICKS=10, DBL_TICKS=4, tick every 4 clk)
REQ-033 Short press: btnDb[0]=1 for 5 ticks, then 0, no further press -> shortPress[0] pulses once, 4 ticks after release; all other outputs 0.
REQ-034 Long hold: btnDb[1]=1 for 15 ticks -> longPress[1] pulses once 1 clk after the 10th tick; held[1]=1 until release; no pulse on release.
REQ-035 Double click: press 2 ticks, release 2 ticks, press 1 tick, release -> dblClick[0] one pulse 1 clk after the second release; no shortPress.
REQ-036 Edge/tick collision: in PRESS1, release on the same clk as the 10th tick -> no longPress; with BTN_EVENT_DBLCLK_EN the channel enters WAIT2, without it shortPress pulses.
REQ-037 Reset mid-hold: rst=0 asserted at tick 6 of a hold on btnDb[0] -> outputs 0 immediately; button still pressed when rst releases -> a new PRESS1 starts.
REQ-038 Independence: both buttons pressed together, [0] short and [1] long -> shortPress[0] and longPress[1] fire at their own times without interference.
